// File: rtl/reno_timeout_backoff_engine.sv
// Per-flow Reno retransmission-timeout engine: one timeout event per transaction in, collapsed
// cwnd/ssthresh, retransmit range and exponentially backed-off RTO out; ack progress clears backoff.
module reno_timeout_backoff_engine #(
    parameter int unsigned FLOW_ID_W    = 4,
    parameter int unsigned SEQ_W        = 32,
    parameter int unsigned WIN_W        = 9,
    parameter int unsigned TIMER_W      = 16,
    parameter int unsigned MAX_BACKOFF  = 6,
    parameter int unsigned RTX_MODE     = 0,
    parameter int unsigned MIN_SSTHRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOW_ID_W-1:0] in_flow_id,
    input  logic [SEQ_W-1:0]     in_wnd_start,
    input  logic [SEQ_W-1:0]     in_next_new,
    input  logic [WIN_W-1:0]     in_wnd_size,
    input  logic [TIMER_W-1:0]   in_rtx_timer,
    input  logic                 ack_adv_valid,
    input  logic [FLOW_ID_W-1:0] ack_adv_flow_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOW_ID_W-1:0] out_flow_id,
    output logic                 out_mark_rtx,
    output logic [SEQ_W-1:0]     out_rtx_start,
    output logic [SEQ_W-1:0]     out_rtx_end,
    output logic [WIN_W-1:0]     out_wnd_size,
    output logic [WIN_W-1:0]     out_ss_thresh,
    output logic [TIMER_W-1:0]   out_rtx_timer,
    output logic [3:0]           out_backoff
);

    localparam int unsigned DEPTH = 1 << FLOW_ID_W;
    localparam int unsigned BO_W  = 4;
    localparam int unsigned SHW   = TIMER_W + 15;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic [FLOW_ID_W-1:0] flow_q;
    logic [SEQ_W-1:0]     wnd_start_q;
    logic [SEQ_W-1:0]     next_new_q;
    logic [WIN_W-1:0]     wnd_size_q;
    logic [TIMER_W-1:0]   rtx_timer_q;
    logic [BO_W-1:0]      table_q [DEPTH];

    logic                 out_valid_q;
    logic [FLOW_ID_W-1:0] out_flow_q;
    logic                 out_mark_q;
    logic [SEQ_W-1:0]     out_start_q;
    logic [SEQ_W-1:0]     out_end_q;
    logic [WIN_W-1:0]     out_wnd_q;
    logic [WIN_W-1:0]     out_ssth_q;
    logic [TIMER_W-1:0]   out_rto_q;
    logic [BO_W-1:0]      out_bo_q;

    logic [BO_W-1:0]      bo_cur;
    logic [BO_W-1:0]      bo_d;
    logic [SHW-1:0]       rto_wide;
    logic [TIMER_W-1:0]   rto_d;
    logic [WIN_W-1:0]     half_wnd;
    logic [WIN_W-1:0]     ssth_d;
    logic                 empty_rng;
    logic [SEQ_W-1:0]     rtx_end_d;

    // Result datapath, evaluated on the captured event while in CALC.
    always_comb begin
        bo_cur    = table_q[flow_q];
        bo_d      = (bo_cur >= BO_W'(MAX_BACKOFF)) ? BO_W'(MAX_BACKOFF) : bo_cur + BO_W'(1);
        rto_wide  = SHW'(rtx_timer_q) << bo_d;
        rto_d     = (rto_wide[SHW-1:TIMER_W] != '0) ? '1 : rto_wide[TIMER_W-1:0];
        half_wnd  = wnd_size_q >> 1;
        ssth_d    = (half_wnd < WIN_W'(MIN_SSTHRESH)) ? WIN_W'(MIN_SSTHRESH) : half_wnd;
        empty_rng = (next_new_q == wnd_start_q);
        rtx_end_d = next_new_q;
        if (empty_rng) begin
            rtx_end_d = wnd_start_q;
        end else if (RTX_MODE == 0) begin
            rtx_end_d = wnd_start_q + SEQ_W'(1);
        end
    end

    // Control FSM, backoff table and registered outputs. A CALC write is ordered after the
    // ack clear so it wins when both hit the same flow in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            flow_q      <= '0;
            wnd_start_q <= '0;
            next_new_q  <= '0;
            wnd_size_q  <= '0;
            rtx_timer_q <= '0;
            out_valid_q <= 1'b0;
            out_flow_q  <= '0;
            out_mark_q  <= 1'b0;
            out_start_q <= '0;
            out_end_q   <= '0;
            out_wnd_q   <= '0;
            out_ssth_q  <= '0;
            out_rto_q   <= '0;
            out_bo_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= '0;
            end
        end else begin
            if (ack_adv_valid) begin
                table_q[ack_adv_flow_id] <= '0;
            end
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        flow_q      <= in_flow_id;
                        wnd_start_q <= in_wnd_start;
                        next_new_q  <= in_next_new;
                        wnd_size_q  <= in_wnd_size;
                        rtx_timer_q <= in_rtx_timer;
                        in_ready_q  <= 1'b0;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    table_q[flow_q] <= bo_d;
                    out_valid_q     <= 1'b1;
                    out_flow_q      <= flow_q;
                    out_mark_q      <= ~empty_rng;
                    out_start_q     <= wnd_start_q;
                    out_end_q       <= rtx_end_d;
                    out_wnd_q       <= WIN_W'(1);
                    out_ssth_q      <= ssth_d;
                    out_rto_q       <= rto_d;
                    out_bo_q        <= bo_d;
                    state_q         <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_flow_id   = out_flow_q;
    assign out_mark_rtx  = out_mark_q;
    assign out_rtx_start = out_start_q;
    assign out_rtx_end   = out_end_q;
    assign out_wnd_size  = out_wnd_q;
    assign out_ss_thresh = out_ssth_q;
    assign out_rtx_timer = out_rto_q;
    assign out_backoff   = out_bo_q;

endmodule

// File: tb/tb_reno_timeout_backoff_engine.sv
// Directed bench for reno_timeout_backoff_engine: one instance per retransmit mode on shared
// stimulus, a vector table for single transactions plus hand sequences for multi-cycle cases.
module tb_reno_timeout_backoff_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_flow_id;
    logic [31:0] in_wnd_start;
    logic [31:0] in_next_new;
    logic [8:0]  in_wnd_size;
    logic [15:0] in_rtx_timer;
    logic        ack_adv_valid;
    logic [3:0]  ack_adv_flow_id;
    logic        out_ready;

    logic        rdy0, rdy1, vld0, vld1, mark0, mark1;
    logic [3:0]  flow0, flow1, bo0, bo1;
    logic [31:0] st0, st1, end0, end1;
    logic [8:0]  wnd0, wnd1, ssth0, ssth1;
    logic [15:0] rto0, rto1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reno_timeout_backoff_engine #(.RTX_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_flow_id(in_flow_id),
        .in_wnd_start(in_wnd_start), .in_next_new(in_next_new), .in_wnd_size(in_wnd_size),
        .in_rtx_timer(in_rtx_timer), .ack_adv_valid(ack_adv_valid), .ack_adv_flow_id(ack_adv_flow_id),
        .out_valid(vld0), .out_ready(out_ready), .out_flow_id(flow0), .out_mark_rtx(mark0),
        .out_rtx_start(st0), .out_rtx_end(end0), .out_wnd_size(wnd0), .out_ss_thresh(ssth0),
        .out_rtx_timer(rto0), .out_backoff(bo0)
    );

    reno_timeout_backoff_engine #(.RTX_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_flow_id(in_flow_id),
        .in_wnd_start(in_wnd_start), .in_next_new(in_next_new), .in_wnd_size(in_wnd_size),
        .in_rtx_timer(in_rtx_timer), .ack_adv_valid(ack_adv_valid), .ack_adv_flow_id(ack_adv_flow_id),
        .out_valid(vld1), .out_ready(out_ready), .out_flow_id(flow1), .out_mark_rtx(mark1),
        .out_rtx_start(st1), .out_rtx_end(end1), .out_wnd_size(wnd1), .out_ss_thresh(ssth1),
        .out_rtx_timer(rto1), .out_backoff(bo1)
    );

    // ack: 0 none, 1 in accept cycle, 2 in CALC cycle, 3 in HOLD cycle (same flow as the event)
    typedef struct {
        logic [3:0]  flow;
        logic [31:0] ws;
        logic [31:0] nn;
        logic [8:0]  wnd;
        logic [15:0] rto;
        int          ack;
        logic        mark;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [8:0]  ssth;
        logic [15:0] erto;
        logic [3:0]  bo;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic [3:0] flow, input logic [31:0] ws, input logic [31:0] nn,
                                input logic [8:0] wnd, input logic [15:0] rto, input int ack,
                                input logic mark, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [8:0] ssth, input logic [15:0] erto, input logic [3:0] bo);
        vec_t v;
        v.flow = flow; v.ws = ws; v.nn = nn; v.wnd = wnd; v.rto = rto; v.ack = ack;
        v.mark = mark; v.e0 = e0; v.e1 = e1; v.ssth = ssth; v.erto = erto; v.bo = bo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_event(input vec_t v);
        in_valid     = 1'b1;
        in_flow_id   = v.flow;
        in_wnd_start = v.ws;
        in_next_new  = v.nn;
        in_wnd_size  = v.wnd;
        in_rtx_timer = v.rto;
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s.ready_timeout: in_ready stayed 0 expected 1", tag);
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, ".valid0"}, 64'(vld0), 64'(1));
        chk({tag, ".valid1"}, 64'(vld1), 64'(1));
        chk({tag, ".flow"},   64'(flow0), 64'(v.flow));
        chk({tag, ".mark0"},  64'(mark0), 64'(v.mark));
        chk({tag, ".mark1"},  64'(mark1), 64'(v.mark));
        chk({tag, ".start0"}, 64'(st0), 64'(v.ws));
        chk({tag, ".start1"}, 64'(st1), 64'(v.ws));
        chk({tag, ".end0"},   64'(end0), 64'(v.e0));
        chk({tag, ".end1"},   64'(end1), 64'(v.e1));
        chk({tag, ".wnd"},    64'({wnd0, wnd1}), 64'({9'd1, 9'd1}));
        chk({tag, ".ssth"},   64'({ssth0, ssth1}), 64'({v.ssth, v.ssth}));
        chk({tag, ".rto"},    64'({rto0, rto1}), 64'({v.erto, v.erto}));
        chk({tag, ".bo"},     64'({bo0, bo1}), 64'({v.bo, v.bo}));
    endtask

    // One full transaction with out_ready held high; checks latency, result and return to IDLE.
    task automatic do_txn(input string tag, input vec_t v);
        bit ok;
        wait_ready(tag, ok);
        if (!ok) return;
        drive_event(v);
        ack_adv_flow_id = v.flow;
        ack_adv_valid   = (v.ack == 1);
        @(posedge clk);
        @(negedge clk);
        in_valid      = 1'b0;
        ack_adv_valid = (v.ack == 2);
        chk({tag, ".calc_valid"}, 64'(vld0), 64'(0));
        chk({tag, ".calc_ready"}, 64'(rdy0), 64'(0));
        @(negedge clk);
        ack_adv_valid = (v.ack == 3);
        chk_result(tag, v);
        @(negedge clk);
        ack_adv_valid = 1'b0;
        chk({tag, ".done_valid"}, 64'(vld0), 64'(0));
        chk({tag, ".done_ready"}, 64'(rdy0), 64'(1));
    endtask

    initial begin
        vec_t  pv;
        vec_t  qv;
        bit    ok;
        logic [3:0] b;

        rst = 1'b1; in_valid = 1'b0; in_flow_id = '0; in_wnd_start = '0; in_next_new = '0;
        in_wnd_size = '0; in_rtx_timer = '0; ack_adv_valid = 1'b0; ack_adv_flow_id = '0;
        out_ready = 1'b1;

        vecs[0] = mk(4'd3, 32'd100, 32'd110, 9'd20, 16'd50, 0, 1'b1, 32'd101, 32'd110, 9'd10, 16'd100, 4'd1);
        for (int i = 1; i <= 8; i++) begin
            b = (i > 6) ? 4'd6 : 4'(i);
            vecs[i] = mk(4'd5, 32'd1000, 32'd1005, 9'd64, 16'd50, 0, 1'b1, 32'd1001, 32'd1005, 9'd32,
                         16'(50 << b), b);
        end
        vecs[9]  = mk(4'd5, 32'd1000, 32'd1005, 9'd64, 16'h4000, 0, 1'b1, 32'd1001, 32'd1005, 9'd32, 16'hFFFF, 4'd6);
        vecs[10] = mk(4'd7, 32'hFFFF_FFFE, 32'd3, 9'd3, 16'd10, 0, 1'b1, 32'hFFFF_FFFF, 32'd3, 9'd2, 16'd20, 4'd1);
        vecs[11] = mk(4'd7, 32'd7, 32'd7, 9'd0, 16'd10, 0, 1'b0, 32'd7, 32'd7, 9'd2, 16'd40, 4'd2);
        vecs[12] = mk(4'd8, 32'hFFFF_FFFF, 32'h10, 9'd511, 16'd1000, 0, 1'b1, 32'd0, 32'h10, 9'd255, 16'd2000, 4'd1);
        vecs[13] = mk(4'd3, 32'd100, 32'd110, 9'd20, 16'd50, 0, 1'b1, 32'd101, 32'd110, 9'd10, 16'd200, 4'd2);
        vecs[14] = mk(4'd9, 32'd5, 32'd6, 9'd4, 16'h8000, 0, 1'b1, 32'd6, 32'd6, 9'd2, 16'hFFFF, 4'd1);
        vecs[15] = mk(4'd10, 32'd5, 32'd6, 9'd5, 16'h7FFF, 0, 1'b1, 32'd6, 32'd6, 9'd2, 16'hFFFE, 4'd1);
        vecs[16] = mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 2, 1'b1, 32'd1, 32'd1, 9'd4, 16'd2, 4'd1);
        vecs[17] = mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 0, 1'b1, 32'd1, 32'd1, 9'd4, 16'd4, 4'd2);
        vecs[18] = mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 3, 1'b1, 32'd1, 32'd1, 9'd4, 16'd8, 4'd3);
        vecs[19] = mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 0, 1'b1, 32'd1, 32'd1, 9'd4, 16'd2, 4'd1);
        vecs[20] = mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 1, 1'b1, 32'd1, 32'd1, 9'd4, 16'd2, 4'd1);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.valid", 64'({vld0, vld1}), 64'(0));
        chk("rst.ready", 64'({rdy0, rdy1}), 64'(0));
        chk("rst.data0", 64'({flow0, mark0, wnd0, ssth0, rto0, bo0}), 64'(0));
        chk("rst.seq0",  64'({st0, end0}), 64'(0));
        chk("rst.seq1",  64'({st1, end1}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            do_txn($sformatf("v%0d", i), vecs[i]);
        end

        // backpressure: result held 10 cycles, a second event waits for the handshake
        pv = mk(4'd12, 32'd50, 32'd60, 9'd10, 16'd5, 0, 1'b1, 32'd51, 32'd60, 9'd5, 16'd10, 4'd1);
        qv = mk(4'd13, 32'd200, 32'd201, 9'd2, 16'd7, 0, 1'b1, 32'd201, 32'd201, 9'd2, 16'd14, 4'd1);
        out_ready = 1'b0;
        wait_ready("bp", ok);
        if (ok) begin
            drive_event(pv);
            @(posedge clk);
            @(negedge clk);
            drive_event(qv);
            @(negedge clk);
            chk_result("bp.first", pv);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk($sformatf("bp.hold%0d.valid", c), 64'(vld0), 64'(1));
                chk($sformatf("bp.hold%0d.ready", c), 64'(rdy0), 64'(0));
                chk($sformatf("bp.hold%0d.data", c), 64'({flow0, rto0, end0}), 64'({4'd12, 16'd10, 32'd51}));
                chk($sformatf("bp.hold%0d.end1", c), 64'(end1), 64'(32'd60));
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp.idle.valid", 64'(vld0), 64'(0));
            chk("bp.idle.ready", 64'(rdy0), 64'(1));
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp.second.calc", 64'({vld0, rdy0}), 64'(0));
            @(negedge clk);
            chk_result("bp.second", qv);
            @(negedge clk);
            chk("bp.second.done", 64'(vld0), 64'(0));
        end

        // reset while in CALC discards the event and clears the table
        pv = mk(4'd5, 32'd1000, 32'd1005, 9'd64, 16'd50, 0, 1'b1, 32'd1001, 32'd1005, 9'd32, 16'd100, 4'd1);
        wait_ready("rc", ok);
        if (ok) begin
            drive_event(pv);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            chk("rc.in_rst", 64'({vld0, vld1, rdy0, rdy1}), 64'(0));
            chk("rc.in_rst.bo", 64'({bo0, bo1}), 64'(0));
            rst = 1'b0;
            @(negedge clk);
            chk("rc.after.ready", 64'({rdy0, rdy1}), 64'(2'b11));
            chk("rc.after.valid", 64'({vld0, vld1}), 64'(0));
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk($sformatf("rc.quiet%0d", c), 64'({vld0, vld1}), 64'(0));
            end
            do_txn("rc.flow5", pv);
            do_txn("rc.flow3", mk(4'd3, 32'd100, 32'd110, 9'd20, 16'd50, 0, 1'b1, 32'd101, 32'd110,
                                  9'd10, 16'd100, 4'd1));
            do_txn("rc.flow11", mk(4'd11, 32'd0, 32'd1, 9'd8, 16'd1, 0, 1'b1, 32'd1, 32'd1,
                                   9'd4, 16'd2, 4'd1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
